// File: rtl/free_list_bank.sv
// One bank of the rename free list: circular FIFO of free upper-PR indices with occupancy flags.
// Optional define FREE_LIST_BANK_BYPASS_EN lets an enqueue into an empty bank be consumed in the same cycle.
module free_list_bank #(
  parameter int LENGTH          = 32,
  parameter int INIT_COUNT      = 16,
  parameter int INIT_BASE       = 16,
  parameter int LOWER_THRESHOLD = 8,
  parameter int UPPER_THRESHOLD = 24
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enq_valid,
  input  logic [4:0]                 enq_upper_PR,
  output logic                       deq_valid,
  output logic [4:0]                 deq_upper_PR,
  input  logic                       deq_ready,
  output logic [$clog2(LENGTH):0]    count,
  output logic                       below_lower,
  output logic                       above_upper,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(LENGTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] LOWER_CNT = CNT_W'(LOWER_THRESHOLD);
  localparam logic [CNT_W-1:0] UPPER_CNT = CNT_W'(UPPER_THRESHOLD);

  logic [4:0]       mem_q [LENGTH];
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic isEmpty, isFull, popFire, bypassFire, enqAccept;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == FULL_CNT);
  assign popFire = !isEmpty && deq_ready;

`ifdef FREE_LIST_BANK_BYPASS_EN
  logic bypassActive;
  assign bypassActive = isEmpty && enq_valid;
  assign bypassFire   = bypassActive && deq_ready;
  assign deq_valid    = !isEmpty || bypassActive;
  assign deq_upper_PR = bypassActive ? enq_upper_PR : mem_q[headPtr_q];
`else
  assign bypassFire   = 1'b0;
  assign deq_valid    = !isEmpty;
  assign deq_upper_PR = mem_q[headPtr_q];
`endif

  // A full bank still accepts a write when the head slot is popped in the same cycle.
  assign enqAccept = enq_valid && (!isFull || popFire) && !bypassFire;

  always_comb begin
    headPtr_d  = headPtr_q;
    tailPtr_d  = tailPtr_q;
    overflow_d = overflow_q;
    if (popFire)   headPtr_d = headPtr_q + PTR_W'(1);
    if (enqAccept) tailPtr_d = tailPtr_q + PTR_W'(1);
    if (enq_valid && isFull && !popFire) overflow_d = 1'b1;
    count_d = count_q + CNT_W'(enqAccept) - CNT_W'(popFire);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LENGTH; i++) begin
        mem_q[i] <= (i < INIT_COUNT) ? 5'(INIT_BASE + i) : 5'd0;
      end
      headPtr_q  <= '0;
      tailPtr_q  <= PTR_W'(INIT_COUNT % LENGTH);
      count_q    <= CNT_W'(INIT_COUNT);
      overflow_q <= 1'b0;
    end else begin
      if (enqAccept) mem_q[tailPtr_q] <= enq_upper_PR;
      headPtr_q  <= headPtr_d;
      tailPtr_q  <= tailPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count        = count_q;
  assign below_lower  = (count_q < LOWER_CNT);
  assign above_upper  = (count_q > UPPER_CNT);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list_bank.sv
// Directed self-checking bench for free_list_bank; expectations follow FREE_LIST_BANK_BYPASS_EN when defined.
module tb_free_list_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enq_valid;
  logic [4:0] enq_upper_PR;
  logic       deq_valid;
  logic [4:0] deq_upper_PR;
  logic       deq_ready;
  logic [5:0] count;
  logic       below_lower;
  logic       above_upper;
  logic       overflow_err;

  int compareCount  = 0;
  int mismatchCount = 0;

  free_list_bank dut (
    .CLK          (CLK),
    .RST          (RST),
    .enq_valid    (enq_valid),
    .enq_upper_PR (enq_upper_PR),
    .deq_valid    (deq_valid),
    .deq_upper_PR (deq_upper_PR),
    .deq_ready    (deq_ready),
    .count        (count),
    .below_lower  (below_lower),
    .above_upper  (above_upper),
    .overflow_err (overflow_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge so combinational outputs can be sampled mid-cycle.
  task automatic applyStimulus(input logic rst, input logic ev, input logic [4:0] pr, input logic dr);
    RST          = rst;
    enq_valid    = ev;
    enq_upper_PR = pr;
    deq_ready    = dr;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [4:0] expQ[$];
    RST = 1'b1; enq_valid = 1'b0; enq_upper_PR = '0; deq_ready = 1'b0;
    step();

    doReset();
    checkOutput("rst_deq_valid", 32'(deq_valid), 32'd1);
    checkOutput("rst_deq_pr", 32'(deq_upper_PR), 32'd16);
    checkOutput("rst_count", 32'(count), 32'd16);
    checkOutput("rst_below", 32'(below_lower), 32'd0);
    checkOutput("rst_above", 32'(above_upper), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_err), 32'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
      checkOutput("pop_valid", 32'(deq_valid), 32'd1);
      checkOutput("pop_pr", 32'(deq_upper_PR), 32'(16 + i));
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_valid", 32'(deq_valid), 32'd0);
    checkOutput("drain_below", 32'(below_lower), 32'd1);

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(5 + i), 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("fill_count", 32'(count), 32'd32);
    checkOutput("fill_above", 32'(above_upper), 32'd1);
    checkOutput("fill_ovf", 32'(overflow_err), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd9, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("ovf_set", 32'(overflow_err), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd32);
    checkOutput("ovf_head", 32'(deq_upper_PR), 32'd16);
    step();
    checkOutput("ovf_sticky", 32'(overflow_err), 32'd1);
    doReset();
    checkOutput("ovf_cleared", 32'(overflow_err), 32'd0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(5 + i), 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1);
    checkOutput("fullswap_pr", 32'(deq_upper_PR), 32'd16);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("fullswap_count", 32'(count), 32'd32);
    checkOutput("fullswap_ovf", 32'(overflow_err), 32'd0);
    expQ.delete();
    for (int v = 17; v <= 31; v++) expQ.push_back(5'(v));
    for (int v = 5; v <= 20; v++) expQ.push_back(5'(v));
    expQ.push_back(5'd3);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
      checkOutput("fullswap_drain", 32'(deq_upper_PR), 32'(expQ[i]));
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("fullswap_empty", 32'(count), 32'd0);

    applyStimulus(1'b0, 1'b1, 5'd7, 1'b1);
`ifdef FREE_LIST_BANK_BYPASS_EN
    checkOutput("byp_valid", 32'(deq_valid), 32'd1);
    checkOutput("byp_pr", 32'(deq_upper_PR), 32'd7);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("byp_count", 32'(count), 32'd0);
    checkOutput("byp_after_valid", 32'(deq_valid), 32'd0);
`else
    checkOutput("nobyp_valid", 32'(deq_valid), 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("nobyp_next_valid", 32'(deq_valid), 32'd1);
    checkOutput("nobyp_next_pr", 32'(deq_upper_PR), 32'd7);
    checkOutput("nobyp_count", 32'(count), 32'd1);
`endif

    doReset();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, 5'(k % 32), 1'b1);
      checkOutput("wrap_pr", 32'(deq_upper_PR), (k < 16) ? 32'(16 + k) : 32'(k - 16));
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("wrap_count", 32'(count), 32'd16);

    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("mid_count", 32'(count), 32'd10);
    applyStimulus(1'b1, 1'b1, 5'd2, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("midrst_count", 32'(count), 32'd16);
    checkOutput("midrst_pr", 32'(deq_upper_PR), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/free_list_bank.md
# free_list_bank

One bank of the rename free list: a circular FIFO of free upper-PR indices for physical registers whose PR bank bits equal this bank's index. Rename dequeues one free upper PR per cycle for new destination mappings. The ROB free path enqueues one upper PR per cycle as committed instructions release their old mappings. Four instances, one per PRF bank, make up the full free list. The threshold flags drive the rename bank-steering logic.

## Interface
Parameters:
- `LENGTH`, default `FREE_LIST_LENGTH_PER_BANK` (32): FIFO capacity; must be a power of 2.
- `INIT_COUNT`, default 16: number of free entries loaded at reset.
- `INIT_BASE`, default 16: first upper PR loaded at reset. At reset, entry i holds `INIT_BASE+i`.
- `LOWER_THRESHOLD`, default `FREE_LIST_LOWER_THRESHOLD` (8).
- `UPPER_THRESHOLD`, default `FREE_LIST_UPPER_THRESHOLD` (24).

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `CLK`, in, 1: clock.
- `RST`, in, 1: synchronous active-high reset.
- `enq_valid`, in, 1: ROB frees a PR of this bank.
- `enq_upper_PR`, in, `upper_PR_t` (5): freed upper PR.
- `deq_valid`, out, 1: a free PR is available.
- `deq_upper_PR`, out, `upper_PR_t`: PR at head (or bypassed PR).
- `deq_ready`, in, 1: rename consumes the PR. This pops only when `deq_valid`=1.
- `count`, out, `$clog2(LENGTH)+1` (6): current occupancy.
- `below_lower`, out, 1: `count < LOWER_THRESHOLD`.
- `above_upper`, out, 1: `count > UPPER_THRESHOLD`.
- `overflow_err`, out, 1: sticky error flag.

## Operation
- Storage: `LENGTH` × `upper_PR_t` register array, plus head pointer and tail pointer.
  - Each pointer is `$clog2(LENGTH)` bits and wraps modulo `LENGTH` naturally.
  - A separate 6-bit `count` register holds occupancy (range 0..`LENGTH`).
- Reset state:
  - Array[i] = `INIT_BASE+i` for i < `INIT_COUNT`; remaining entries are 0.
  - head = 0, tail = `INIT_COUNT` mod `LENGTH`, count = `INIT_COUNT`.
  - overflow_err = 0.
  - Resulting outputs with defaults: `deq_valid`=1, `deq_upper_PR`=16, `count`=16, `below_lower`=0, `above_upper`=0.
- Enqueue: if `enq_valid` and count < `LENGTH`, write array[tail], then tail++.
- Enqueue while full, without a same-cycle pop:
  - The write is dropped and tail is unchanged.
  - `overflow_err` sets and holds until `RST`.
  - Correct core operation never reaches this state; it is a verification check.
- Dequeue: `deq_valid` = (count != 0); `deq_upper_PR` = array[head]. On `deq_valid & deq_ready`, head++.
- Simultaneous enq and deq with count in 1..`LENGTH`-1:
  - Both pointers advance and count is unchanged.
  - Enqueue at count=`LENGTH` with a same-cycle pop is legal. It writes the slot being freed (tail = head) and does not set the error flag.
- Count update: count_next = count + enq_accepted − deq_fire.
- `below_lower` and `above_upper` are combinational from the registered `count`.
- `RST` asserted mid-operation discards all contents and restores the reset state on the next edge, regardless of same-cycle enq/deq.

## Timing
- Enqueue-to-dequeue latency through the array: 1 cycle. An entry written at edge N is visible at the head no earlier than cycle N+1.
- `deq_valid`, `deq_upper_PR`, `count` and the flags are driven from registers (plus the array read mux).
  - There is no combinational path from `enq_*` to `deq_*` unless bypass is enabled (see Configuration).
  - There is no combinational path from `deq_ready` to any output.
- Throughput: one enqueue and one dequeue per cycle, sustained.

## Configuration
- `FREE_LIST_BANK_BYPASS_EN` defined: when count = 0 and `enq_valid`=1:
  - `deq_valid`=1 and `deq_upper_PR`=`enq_upper_PR` combinationally.
  - If `deq_ready`=1, the PR is consumed directly: no write, pointers unchanged, count stays 0.
  - If `deq_ready`=0, a normal enqueue occurs.
- `FREE_LIST_BANK_BYPASS_EN` undefined:
  - count = 0 always gives `deq_valid`=0.
  - An enqueue to an empty bank is dequeuable from the next cycle.

## Test plan
- Reset, then 16 back-to-back pops with `deq_ready`=1 and no enq:
  - Outputs 16,17,…,31 in order.
  - After the 16th pop: count = 0, `deq_valid`=0, `below_lower`=1.
- From reset, enqueue 5,6,…,20 (16 enqs) with no deq:
  - count reaches 32 and `above_upper`=1.
  - A 17th enq of 9 sets `overflow_err`=1; count stays 32.
  - A later `RST` clears the flag.
- Count 32 with enq=3 and deq in the same cycle:
  - Head value is popped, count stays 32, `overflow_err`=0.
  - After draining, 3 is output last.
- Empty bank, enq=7 with `deq_ready`=1:
  - With bypass: `deq_valid`=1, `deq_upper_PR`=7 in the same cycle, count stays 0.
  - Without bypass: `deq_valid`=0 that cycle, then 7 is valid the next cycle.
- Wrap-around: 40 cycles of simultaneous enq (values 0..39 mod 32) and deq starting from reset state:
  - The output order is exactly FIFO across pointer wrap.
  - count holds at 16.
- `RST` asserted during simultaneous enq/deq at count = 10: next cycle count = 16 and `deq_upper_PR` = 16.
